ram_dma_engine: RTL and testbench
=================================

RAM_DMA_ENGINE -- requirements
Module: ram_dma_engine

Interface
REQ-001 The module SHALL take parameter NUM_RAM_ADDRESS, default 256, which sets the RAM depth in 32-bit words.
REQ-002 The module SHALL take parameter AW, default $clog2(NUM_RAM_ADDRESS), which sets the address width.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset; ports clk and reset are named as elsewhere in the codebase.
REQ-004 The module SHALL provide these ports:
- clk, input, 1 bit: system clock; all logic on the rising edge.
- reset, input, 1 bit: asynchronous, active-low reset.
- start, input, 1 bit: copy request, sampled in IDLE.
- src_addr, input, AW bits: first source word address.
- dst_addr, input, AW bits: first destination word address.
- length, input, AW+1 bits: number of words to copy.
- busy, output, 1 bit: high while a copy is in progress.
- done, output, 1 bit: one-cycle completion pulse.
- checksum, output, 32 bits: sum of the copied words.
- ram_data_read_in, input, 32 bits: RAM read data.
- ram_address, output, AW bits: RAM word address.
- ram_data_write_out, output, 32 bits: RAM write data.
- ram_enable, output, 1 bit: RAM access strobe.
- ram_read_write, output, 1 bit: 1 means write, 0 means read.

Function
REQ-005 The block SHALL be a RAM initiator that is pin-compatible with the processor's RAM port, and it SHALL copy length words from src_addr to dst_addr.
REQ-006 The block SHALL implement an FSM with exactly these states: IDLE, RD, CAP, WR, FIN.
REQ-007 In IDLE, when start=1, the block SHALL latch src_addr, dst_addr and length; a latched length above NUM_RAM_ADDRESS SHALL be clamped to NUM_RAM_ADDRESS; the block SHALL clear the word index and checksum; it SHALL go to RD if length≠0 and to FIN if length=0.
REQ-008 In RD, the block SHALL drive ram_enable=1, ram_read_write=0 and ram_address=(src+idx) mod NUM_RAM_ADDRESS, then go to CAP.
REQ-009 RAM read data SHALL be taken as valid in the cycle after the RD cycle.
REQ-010 In CAP, the block SHALL drive ram_enable=0, register ram_data_read_in into a data register, add the value to checksum mod 2^32, then go to WR.
REQ-011 In WR, the block SHALL drive ram_enable=1, ram_read_write=1, ram_address=(dst+idx) mod NUM_RAM_ADDRESS and ram_data_write_out=data register, then increment idx.
REQ-012 From WR, the block SHALL go to FIN if idx+1 = latched length, otherwise to RD.
REQ-013 In FIN, the block SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-014 Throughput SHALL be exactly 3 cycles per word, with no idle cycles between words.
REQ-015 Total latency SHALL be 3·length+1 cycles from the start-sampling edge to the done cycle inclusive.
REQ-016 busy SHALL equal 1 in RD, CAP, WR and FIN, and 0 in IDLE.
REQ-017 start SHALL be ignored in every state other than IDLE, including the FIN cycle.
REQ-018 Source and destination addresses SHALL wrap independently modulo NUM_RAM_ADDRESS.
REQ-019 Overlapping source and destination ranges SHALL be copied strictly in ascending index order, with no hazard protection.
REQ-020 ram_enable SHALL be 0 in IDLE, CAP and FIN.
REQ-021 ram_read_write SHALL be 0 whenever ram_enable=0.
REQ-022 ram_address and ram_data_write_out SHALL hold their last values whenever ram_enable=0.
REQ-023 checksum SHALL hold its final value after done until the next accepted start.

Reset
REQ-024 While reset=0, the FSM SHALL be in IDLE and all of these SHALL be 0: busy, done, checksum, ram_enable, ram_read_write, ram_address, ram_data_write_out and the internal index and data registers.
REQ-025 Reset asserted mid-copy SHALL abort immediately and asynchronously with no further RAM write, leaving RAM contents already written unchanged.
REQ-026 After reset deasserts, the block SHALL wait in IDLE for a new start.

Verification
REQ-027 Basic copy: RAM[10..13]=1,2,3,4; start with src=10, dst=100, len=4 -> RAM[100..103]=1,2,3,4, done pulses 13 cycles after the start edge, checksum=10.
REQ-028 Zero length: start with len=0 -> no ram_enable pulse, busy for 1 cycle, done on the cycle after the start edge, checksum=0.
REQ-029 Wrap-around: RAM[254]=0xA, RAM[255]=0xB, RAM[0]=0xC; start with src=254, dst=20, len=3 -> RAM[20..22]=0xA,0xB,0xC, checksum=0x21.
REQ-030 Checksum overflow: copy 2 words of 0xFFFFFFFF -> checksum=0xFFFFFFFE.
REQ-031 Busy and abort: a second start pulse while busy is ignored and exactly one done is seen; reset=0 asserted during the CAP of word 2 of a 4-word copy -> only 1 destination word written, all outputs 0, and a following start runs normally.
REQ-032 Clamp and protocol checks: len=300 on depth 256 -> exactly 256 writes; an assertion checks that ram_read_write=1 implies ram_enable=1 on every cycle.

Source files
------------

// File: rtl/ram_dma_engine.sv
// RAM-to-RAM copy engine driving a processor-style single RAM port.
// Each word takes a read, a capture and a write cycle; a running checksum sums the copied words.
module ram_dma_engine #(
  parameter int unsigned NUM_RAM_ADDRESS = 256,
  parameter int unsigned AW              = $clog2(NUM_RAM_ADDRESS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   length,
  output logic          busy,
  output logic          done,
  output logic [31:0]   checksum,
  input  logic [31:0]   ram_data_read_in,
  output logic [AW-1:0] ram_address,
  output logic [31:0]   ram_data_write_out,
  output logic          ram_enable,
  output logic          ram_read_write
);

  typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StFin} state_e;

  localparam logic [AW:0]   MaxLen = (AW+1)'(NUM_RAM_ADDRESS);
  localparam logic [AW+1:0] Depth  = (AW+2)'(NUM_RAM_ADDRESS);

  state_e        state_q, state_d;
  logic [AW-1:0] src_q, dst_q;
  logic [AW:0]   len_q, idx_q, len_clamped;
  logic [31:0]   data_q, checksum_q, wdata_q;
  logic [AW-1:0] addr_q, rd_addr, wr_addr;
  logic [AW+1:0] rd_sum, wr_sum;

  assign len_clamped = (length > MaxLen) ? MaxLen : length;

  // Base plus index never exceeds twice the depth, so one conditional subtract wraps it.
  always_comb begin
    rd_sum  = {2'b00, src_q} + {1'b0, idx_q};
    wr_sum  = {2'b00, dst_q} + {1'b0, idx_q};
    rd_addr = (rd_sum >= Depth) ? AW'(rd_sum - Depth) : AW'(rd_sum);
    wr_addr = (wr_sum >= Depth) ? AW'(wr_sum - Depth) : AW'(wr_sum);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = (length == '0) ? StFin : StRd;
      StRd:   state_d = StCap;
      StCap:  state_d = StWr;
      StWr:   state_d = (idx_q + (AW+1)'(1) == len_q) ? StFin : StRd;
      StFin:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Address and write data fall back to their registered copies so they hold while idle.
  always_comb begin
    busy               = (state_q != StIdle);
    done               = (state_q == StFin);
    ram_enable         = (state_q == StRd) || (state_q == StWr);
    ram_read_write     = (state_q == StWr);
    ram_address        = addr_q;
    ram_data_write_out = wdata_q;
    if (state_q == StRd) ram_address = rd_addr;
    if (state_q == StWr) begin
      ram_address        = wr_addr;
      ram_data_write_out = data_q;
    end
  end

  assign checksum = checksum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      checksum_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= ram_address;
      wdata_q <= ram_data_write_out;
      case (state_q)
        StIdle: begin
          if (start) begin
            src_q      <= src_addr;
            dst_q      <= dst_addr;
            len_q      <= len_clamped;
            idx_q      <= '0;
            checksum_q <= '0;
          end
        end
        StCap: begin
          data_q     <= ram_data_read_in;
          checksum_q <= checksum_q + ram_data_read_in;
        end
        StWr:    idx_q <= idx_q + (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dma_engine.sv
// Self-checking bench: behavioural RAM plus a sequential-copy reference model.
`timescale 1ns/1ps
module tb_ram_dma_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  src_addr, dst_addr;
  logic [8:0]  length;
  logic        busy, done;
  logic [31:0] checksum;
  logic [31:0] ram_data_read_in;
  logic [7:0]  ram_address;
  logic [31:0] ram_data_write_out;
  logic        ram_enable, ram_read_write;

  logic [31:0] mem [256];
  logic        tb_we;
  logic [7:0]  tb_addr;
  logic [31:0] tb_data;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int en_cnt = 0;
  int done_cnt = 0;

  ram_dma_engine #(.NUM_RAM_ADDRESS(256)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .src_addr          (src_addr),
    .dst_addr          (dst_addr),
    .length            (length),
    .busy              (busy),
    .done              (done),
    .checksum          (checksum),
    .ram_data_read_in  (ram_data_read_in),
    .ram_address       (ram_address),
    .ram_data_write_out(ram_data_write_out),
    .ram_enable        (ram_enable),
    .ram_read_write    (ram_read_write)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (ram_enable && ram_read_write) begin
      mem[ram_address] <= ram_data_write_out;
      wr_cnt <= wr_cnt + 1;
    end
    if (ram_enable) en_cnt <= en_cnt + 1;
    if (ram_enable && !ram_read_write) ram_data_read_in <= mem[ram_address];
    if (tb_we) mem[tb_addr] <= tb_data;
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    checks++;
    assert (!ram_read_write || ram_enable) else begin
      errors++;
      $error("FAIL proto: rw=%0b en=%0b expected rw=0 when en=0", ram_read_write, ram_enable);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a[7:0]; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic check_mem(input string tag, input logic [31:0] exp [256]);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp[i]) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  // Model: copy word by word in ascending order, so overlapping ranges see earlier writes.
  task automatic run_copy(input int s, input int d, input int l, input bit extra_start);
    logic [31:0] exp [256];
    logic [31:0] sum = '0;
    int n, k, done_k, w0, e0, d0;
    n = (l > 256) ? 256 : l;
    for (int i = 0; i < 256; i++) exp[i] = mem[i];
    for (int i = 0; i < n; i++) begin
      exp[(d + i) % 256] = exp[(s + i) % 256];
      sum += exp[(d + i) % 256];
    end
    w0 = wr_cnt; e0 = en_cnt; d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; src_addr = s[7:0]; dst_addr = d[7:0]; length = l[8:0];
    @(posedge clk);
    done_k = -1; k = 0;
    while (done_k < 0 && k < 4000) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0;
        check("busy_first", {31'd0, busy}, 32'd1);
      end
      if (extra_start && k == 2) begin
        start = 1'b1; src_addr = 8'd0; dst_addr = 8'd1; length = 9'd5;
      end
      if (extra_start && k == 3) start = 1'b0;
      if (done) begin
        done_k = k;
        if (extra_start) start = 1'b1;
      end
    end
    check("latency", 32'(done_k), 32'(3 * n + 1));
    @(negedge clk);
    start = 1'b0;
    check("busy_after", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("checksum", checksum, sum);
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("writes", 32'(wr_cnt - w0), 32'(n));
    check("enables", 32'(en_cnt - e0), 32'(2 * n));
    check_mem("mem", exp);
  endtask

  initial begin
    logic [31:0] exp [256];
    int s, d, l;
    reset = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_checksum", checksum, 32'd0);
    check("rst_en", {31'd0, ram_enable}, 32'd0);
    check("rst_rw", {31'd0, ram_read_write}, 32'd0);
    check("rst_addr", {24'd0, ram_address}, 32'd0);
    check("rst_wdata", ram_data_write_out, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 256; i++) poke(i, $urandom);
    for (int i = 0; i < 4; i++) poke(10 + i, 32'(i + 1));
    poke(254, 32'hA); poke(255, 32'hB); poke(0, 32'hC);
    poke(200, 32'hFFFF_FFFF); poke(201, 32'hFFFF_FFFF);

    run_copy(10, 100, 4, 1'b1);
    check("basic_sum", checksum, 32'd10);
    run_copy(5, 6, 0, 1'b0);
    check("zero_sum", checksum, 32'd0);
    run_copy(254, 20, 3, 1'b0);
    check("wrap_sum", checksum, 32'h21);
    run_copy(200, 210, 2, 1'b0);
    check("ovf_sum", checksum, 32'hFFFF_FFFE);

    for (int t = 0; t < 6; t++) begin
      s = int'($urandom_range(0, 255));
      d = (t % 2 == 0) ? (s + int'($urandom_range(1, 3))) % 256 : int'($urandom_range(0, 255));
      l = int'($urandom_range(1, 12));
      run_copy(s, d, l, 1'b0);
    end

    run_copy(7, 50, 300, 1'b0);

    // Abort during the capture cycle of the second word.
    for (int i = 0; i < 256; i++) exp[i] = mem[i];
    exp[60] = mem[40];
    s = wr_cnt;
    @(negedge clk);
    start = 1'b1; src_addr = 8'd40; dst_addr = 8'd60; length = 9'd4;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    check("abort_cap_en", {31'd0, ram_enable}, 32'd0);
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_checksum", checksum, 32'd0);
    check("abort_en", {31'd0, ram_enable}, 32'd0);
    check("abort_rw", {31'd0, ram_read_write}, 32'd0);
    check("abort_addr", {24'd0, ram_address}, 32'd0);
    check("abort_wdata", ram_data_write_out, 32'd0);
    repeat (3) @(negedge clk);
    check("abort_writes", 32'(wr_cnt - s), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("idle_after_abort", {31'd0, busy}, 32'd0);
    check_mem("abort_mem", exp);

    run_copy(30, 90, 5, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
